pe_net_interface: RTL and testbench

//  Leaf-side network interface between one processing element (PE) and its parent switch in the binary-tree NoC.
//  TX: packs PE payload plus destination into a flit {dest, payload}, buffers it in a TX FIFO and drives the switch input.
//  RX: accepts flits from the switch, keeps those addressed to MyAddr, strips the header and presents the payload to the PE.
//  All four interfaces use valid/ready; a transfer occurs on a cycle where valid & ready are both high at the i_sclk rising edge.

---
 rtl/pe_net_interface.sv | 156 +++++++++++++++
 tb/tb_pe_net_interface.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_net_interface.sv
// rtl/pe_net_interface.sv - PE-side tree-NoC interface: TX FWFT flit FIFO, RX 2-entry skid buffer with address filter.
// Optional macro NI_DROP_CNT_EN enables the saturating misrouted-flit counter on o_drop_count.
module pe_net_interface #(
    parameter  int DataWidth = 36,
    parameter  int AddrWidth = 4,
    parameter  int MyAddr    = 0,
    parameter  int TxDepth   = 4,
    localparam int PW        = DataWidth - AddrWidth,
    localparam int LW        = $clog2(TxDepth + 1)
) (
    input  logic                 i_sclk,
    input  logic                 i_resetn,
    input  logic [PW-1:0]        i_pe_data,
    input  logic [AddrWidth-1:0] i_pe_dest,
    input  logic                 i_pe_valid,
    output logic                 o_pe_ready,
    output logic [DataWidth-1:0] o_net_data,
    output logic                 o_net_valid,
    input  logic                 i_net_ready,
    input  logic [DataWidth-1:0] i_net_data,
    input  logic                 i_net_valid,
    output logic                 o_net_ready,
    output logic [PW-1:0]        o_pe_rx_data,
    output logic                 o_pe_rx_valid,
    input  logic                 i_pe_rx_ready,
    output logic [LW-1:0]        o_tx_level,
    output logic [15:0]          o_drop_count
);

    localparam int PtrW = $clog2(TxDepth);

    logic [DataWidth-1:0] tx_mem [TxDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [LW-1:0]        tx_level;
    logic                 tx_push;
    logic                 tx_pop;

    // Ready depends only on the stored level, so a full FIFO refuses even when popping.
    assign o_pe_ready  = (tx_level != LW'(TxDepth));
    assign o_net_valid = (tx_level != '0);
    assign tx_push     = i_pe_valid & o_pe_ready;
    assign tx_pop      = o_net_valid & i_net_ready;
    assign o_net_data  = tx_mem[rd_ptr];
    assign o_tx_level  = tx_level;

    always_ff @(posedge i_sclk) begin
        if (tx_push) begin
            tx_mem[wr_ptr] <= {i_pe_dest, i_pe_data};
        end
    end

    always_ff @(posedge i_sclk or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
        end
    end

    typedef enum logic [1:0] {
        RX_EMPTY = 2'd0,
        RX_ONE   = 2'd1,
        RX_FULL  = 2'd2
    } rx_state_t;

    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic [PW-1:0] rx_head;
    logic [PW-1:0] rx_tail;
    logic          rx_hit;
    logic          rx_accept;
    logic          rx_store;
    logic          rx_read;

    assign rx_hit        = (i_net_data[DataWidth-1 -: AddrWidth] == AddrWidth'(MyAddr));
    assign o_net_ready   = (rx_state != RX_FULL);
    assign o_pe_rx_valid = (rx_state != RX_EMPTY);
    assign o_pe_rx_data  = rx_head;
    assign rx_accept     = i_net_valid & o_net_ready;
    assign rx_store      = rx_accept & rx_hit;
    assign rx_read       = o_pe_rx_valid & i_pe_rx_ready;

    always_ff @(posedge i_sclk or negedge i_resetn) begin
        if (!i_resetn) begin
            rx_state <= RX_EMPTY;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_EMPTY: if (rx_store) rx_next = RX_ONE;
            RX_ONE: begin
                if (rx_store && !rx_read) begin
                    rx_next = RX_FULL;
                end else if (rx_read && !rx_store) begin
                    rx_next = RX_EMPTY;
                end
            end
            RX_FULL:  if (rx_read) rx_next = RX_ONE;
            default:  rx_next = RX_EMPTY;
        endcase
    end

    // Head is always the oldest payload; tail only holds the second entry while full.
    always_ff @(posedge i_sclk) begin
        case (rx_state)
            RX_EMPTY: begin
                if (rx_store) rx_head <= i_net_data[PW-1:0];
            end
            RX_ONE: begin
                if (rx_store && rx_read) begin
                    rx_head <= i_net_data[PW-1:0];
                end else if (rx_store) begin
                    rx_tail <= i_net_data[PW-1:0];
                end
            end
            RX_FULL: begin
                if (rx_read) rx_head <= rx_tail;
            end
            default: ;
        endcase
    end

`ifdef NI_DROP_CNT_EN
    logic [15:0] drop_count;

    always_ff @(posedge i_sclk or negedge i_resetn) begin
        if (!i_resetn) begin
            drop_count <= 16'h0;
        end else if (rx_accept && !rx_hit && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    assign o_drop_count = drop_count;
`else
    assign o_drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_pe_net_interface.sv
// tb/tb_pe_net_interface.sv - self-checking bench for pe_net_interface: vector table plus queue scoreboard model.
module tb_pe_net_interface;

    logic        i_sclk;
    logic        i_resetn;
    logic [31:0] i_pe_data;
    logic [3:0]  i_pe_dest;
    logic        i_pe_valid;
    logic        o_pe_ready;
    logic [35:0] o_net_data;
    logic        o_net_valid;
    logic        i_net_ready;
    logic [35:0] i_net_data;
    logic        i_net_valid;
    logic        o_net_ready;
    logic [31:0] o_pe_rx_data;
    logic        o_pe_rx_valid;
    logic        i_pe_rx_ready;
    logic [2:0]  o_tx_level;
    logic [15:0] o_drop_count;

    pe_net_interface dut (
        .i_sclk        (i_sclk),
        .i_resetn      (i_resetn),
        .i_pe_data     (i_pe_data),
        .i_pe_dest     (i_pe_dest),
        .i_pe_valid    (i_pe_valid),
        .o_pe_ready    (o_pe_ready),
        .o_net_data    (o_net_data),
        .o_net_valid   (o_net_valid),
        .i_net_ready   (i_net_ready),
        .i_net_data    (i_net_data),
        .i_net_valid   (i_net_valid),
        .o_net_ready   (o_net_ready),
        .o_pe_rx_data  (o_pe_rx_data),
        .o_pe_rx_valid (o_pe_rx_valid),
        .i_pe_rx_ready (i_pe_rx_ready),
        .o_tx_level    (o_tx_level),
        .o_drop_count  (o_drop_count)
    );

    initial begin
        i_sclk = 1'b0;
        forever #5 i_sclk = ~i_sclk;
    end

`ifdef NI_DROP_CNT_EN
    localparam logic [15:0] DropAfterOne = 16'd1;
`else
    localparam logic [15:0] DropAfterOne = 16'd0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] sb_tx [$];
    logic [31:0] sb_rx [$];
    int          m_drop = 0;

    typedef struct {
        logic        pv;
        logic [3:0]  pd;
        logic [31:0] pdat;
        logic        nr;
        logic        nv;
        logic [35:0] nd;
        logic        rr;
        logic        e_pe_ready;
        logic [2:0]  e_level;
        logic        e_net_ready;
        logic        e_rx_valid;
    } vec_t;

    vec_t vt [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare DUT against the queue model, then advance model and DUT across one clock edge.
    task automatic step();
        bit push, pop, acc, store, rd;
        #1;
        check("pe_ready",  64'(o_pe_ready),    64'(sb_tx.size() != 4));
        check("net_valid", 64'(o_net_valid),   64'(sb_tx.size() != 0));
        check("tx_level",  64'(o_tx_level),    64'(sb_tx.size()));
        check("net_ready", 64'(o_net_ready),   64'(sb_rx.size() != 2));
        check("rx_valid",  64'(o_pe_rx_valid), 64'(sb_rx.size() != 0));
        check("drop_cnt",  64'(o_drop_count),  64'(m_drop));
        push  = i_pe_valid && (sb_tx.size() != 4);
        pop   = i_net_ready && (sb_tx.size() != 0);
        acc   = i_net_valid && (sb_rx.size() != 2);
        store = acc && (i_net_data[35:32] == 4'h0);
        rd    = i_pe_rx_ready && (sb_rx.size() != 0);
        if (pop) begin
            check("net_data", 64'(o_net_data), 64'(sb_tx[0]));
            void'(sb_tx.pop_front());
        end
        if (push) sb_tx.push_back({i_pe_dest, i_pe_data});
        if (rd) begin
            check("rx_data", 64'(o_pe_rx_data), 64'(sb_rx[0]));
            void'(sb_rx.pop_front());
        end
        if (store) sb_rx.push_back(i_net_data[31:0]);
`ifdef NI_DROP_CNT_EN
        if (acc && !store && m_drop != 65535) m_drop++;
`endif
        @(posedge i_sclk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pe_valid    = 1'b0;
        i_pe_dest     = 4'h0;
        i_pe_data     = 32'h0;
        i_net_ready   = 1'b0;
        i_net_valid   = 1'b0;
        i_net_data    = 36'h0;
        i_pe_rx_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pe_ready"},  64'(o_pe_ready),    64'(1));
        check({tag, " net_ready"}, 64'(o_net_ready),   64'(1));
        check({tag, " net_valid"}, 64'(o_net_valid),   64'(0));
        check({tag, " rx_valid"},  64'(o_pe_rx_valid), 64'(0));
        check({tag, " tx_level"},  64'(o_tx_level),    64'(0));
        check({tag, " drop_cnt"},  64'(o_drop_count),  64'(0));
    endtask

    initial begin
        // TX backpressure: 5 pushes to dest 3, 4 fit, then drain in order.
        for (int i = 0; i < 5; i++)
            vt.push_back('{1'b1, 4'h3, 32'h100 + i, 1'b0, 1'b0, 36'h0, 1'b0, (i != 4), 3'(i), 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0});
        // RX skid: A, B buffered, C waits for the first PE read.
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 36'h0_0000_000A, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 36'h0_0000_000B, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 36'h0_0000_000C, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 36'h0_0000_000C, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 36'h0_0000_000C, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0});
        // Misrouted flit to dest 5 is dropped.
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 36'h5_0000_DEAD, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0});

        idle_inputs();
        i_resetn = 1'b0;
        repeat (2) @(posedge i_sclk);
        #1;
        check_reset_values("in_reset");
        i_resetn = 1'b1;
        #1;
        check_reset_values("released");
        step();

        foreach (vt[i]) begin
            i_pe_valid    = vt[i].pv;
            i_pe_dest     = vt[i].pd;
            i_pe_data     = vt[i].pdat;
            i_net_ready   = vt[i].nr;
            i_net_valid   = vt[i].nv;
            i_net_data    = vt[i].nd;
            i_pe_rx_ready = vt[i].rr;
            #1;
            check($sformatf("vec%0d pe_ready", i),  64'(o_pe_ready),    64'(vt[i].e_pe_ready));
            check($sformatf("vec%0d tx_level", i),  64'(o_tx_level),    64'(vt[i].e_level));
            check($sformatf("vec%0d net_ready", i), 64'(o_net_ready),   64'(vt[i].e_net_ready));
            check($sformatf("vec%0d rx_valid", i),  64'(o_pe_rx_valid), 64'(vt[i].e_rx_valid));
            step();
        end
        check("drop_after_misroute", 64'(o_drop_count), 64'(DropAfterOne));

        // Push and pop together at level 2.
        idle_inputs();
        i_pe_valid = 1'b1;
        i_pe_dest  = 4'h2;
        i_pe_data  = 32'h50;
        step();
        i_pe_data  = 32'h51;
        step();
        i_pe_data   = 32'h52;
        i_net_ready = 1'b1;
        #1;
        check("pp level before", 64'(o_tx_level), 64'(2));
        check("pp head before",  64'(o_net_data), 64'(36'h2_0000_0050));
        step();
        check("pp level after", 64'(o_tx_level), 64'(2));
        check("pp head after",  64'(o_net_data), 64'(36'h2_0000_0051));

        // Random mixed traffic for pointer wrap and RX ordering.
        for (int c = 0; c < 80; c++) begin
            i_pe_valid    = 1'($urandom_range(0, 1));
            i_pe_dest     = 4'($urandom_range(0, 15));
            i_pe_data     = $urandom;
            i_net_ready   = 1'($urandom_range(0, 1));
            i_net_valid   = 1'($urandom_range(0, 1));
            i_net_data    = {($urandom_range(0, 1) != 0) ? 4'h0 : 4'h5, 32'($urandom)};
            i_pe_rx_ready = 1'($urandom_range(0, 1));
            step();
        end
        idle_inputs();
        i_net_ready   = 1'b1;
        i_pe_rx_ready = 1'b1;
        repeat (6) step();

        // Reset with TX level 3 and RX full; nothing stale may emerge afterwards.
        idle_inputs();
        i_pe_valid  = 1'b1;
        i_pe_dest   = 4'h7;
        i_net_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_pe_data  = 32'h700 + k;
            i_net_data = {4'h0, 32'h900 + k};
            step();
        end
        idle_inputs();
        #1;
        check("pre_rst level", 64'(o_tx_level), 64'(3));
        check("pre_rst rx_full", 64'(o_net_ready), 64'(0));
        #1;
        i_resetn = 1'b0;
        #1;
        check_reset_values("async_rst");
        sb_tx.delete();
        sb_rx.delete();
        m_drop = 0;
        @(posedge i_sclk);
        #1;
        i_resetn      = 1'b1;
        i_net_ready   = 1'b1;
        i_pe_rx_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
